disp_scan_ctrl: RTL

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_scan_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 8-digit multiplexed 7-segment scanner with guard slots and frame-synchronous shadow load.
// Define DISP_LZ_BLANK_EN to blank leading-zero digits (digit 0 is always shown).
module disp_scan_ctrl #(
    parameter int DWELL = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DISP_CE,
    input  logic        LOAD,
    input  logic [31:0] HEX_IN,
    input  logic [7:0]  DP_IN,
    input  logic [7:0]  DISP_OFF,
    output logic [7:0]  AN,
    output logic [6:0]  CAT,
    output logic        DP,
    output logic [2:0]  DIG_IDX,
    output logic        LOAD_PEND,
    output logic        FRAME_DONE
);
    typedef enum logic {GUARD, DRIVE} state_t;
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [7:0] LAST = 8'(DWELL - 1);
    state_t      state, state_nxt;
    logic [7:0]  dwell_cnt;
    logic [47:0] ld_data, sh_data;
    logic [31:0] hex_act;
    logic [7:0]  dp_act, off_act, sup;
    logic        dwell_end, boundary, blank;
    logic [7:0]  an_nxt;
    logic [6:0]  cat_nxt;
    logic        dp_nxt;
`ifdef DISP_LZ_BLANK_EN
    logic        zero_run;
`endif

    assign ld_data   = {HEX_IN, DP_IN, DISP_OFF};
    assign dwell_end = DISP_CE && state == DRIVE && dwell_cnt == LAST;
    assign boundary  = dwell_end && DIG_IDX == 3'd7;

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state     <= GUARD;
            dwell_cnt <= 8'd0;
            DIG_IDX   <= 3'd0;
        end else begin
            state <= state_nxt;
            if (DISP_CE) dwell_cnt <= state == GUARD ? 8'd0 : dwell_cnt + 8'd1;
            if (dwell_end) DIG_IDX <= DIG_IDX + 3'd1;
        end

    always_comb
        state_nxt = !DISP_CE ? state : state == GUARD ? DRIVE : dwell_cnt == LAST ? GUARD : DRIVE;

    // LOAD coinciding with the frame boundary bypasses the shadow buffer
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            sh_data                    <= '0;
            {hex_act, dp_act, off_act} <= '0;
            LOAD_PEND                  <= 1'b0;
            FRAME_DONE                 <= 1'b0;
        end else begin
            if (LOAD) sh_data <= ld_data;
            if (boundary && (LOAD || LOAD_PEND)) {hex_act, dp_act, off_act} <= LOAD ? ld_data : sh_data;
            LOAD_PEND  <= !boundary && (LOAD || LOAD_PEND);
            FRAME_DONE <= boundary;
        end

    always_comb begin
        sup = '0;
`ifdef DISP_LZ_BLANK_EN
        zero_run = 1'b1;
        for (int i = 7; i > 0; i--) begin
            zero_run = zero_run && hex_act[4*i +: 4] == 4'h0;
            sup[i]   = zero_run;
        end
`endif
    end

    always_comb begin
        blank   = state == GUARD || off_act[DIG_IDX] || sup[DIG_IDX];
        an_nxt  = blank ? 8'hFF : ~(8'h01 << DIG_IDX);
        cat_nxt = blank ? 7'h7F : SEG[hex_act[{DIG_IDX, 2'b00} +: 4]];
        dp_nxt  = blank || !dp_act[DIG_IDX];
    end

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            AN  <= 8'hFF;
            CAT <= 7'h7F;
            DP  <= 1'b1;
        end else begin
            AN  <= an_nxt;
            CAT <= cat_nxt;
            DP  <= dp_nxt;
        end
endmodule
